// File: rtl/sync_pkg.sv
// sync_pkg: encodings and defaults shared by the period detector and the sync generator.
package sync_pkg;

  localparam int PERIOD_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } sync_state_e;

endpackage

// File: rtl/period_tol_cmp.sv
// period_tol_cmp: combinational |a - b| <= TOL test. The difference is taken one
// bit wider than the operands so that it cannot wrap.
module period_tol_cmp #(
  parameter int W   = 16,
  parameter int TOL = 2
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         match_o
);

  logic [W:0] a_x;
  logic [W:0] b_x;
  logic [W:0] diff;

  assign a_x     = {1'b0, a_i};
  assign b_x     = {1'b0, b_i};
  assign diff    = (a_x >= b_x) ? (a_x - b_x) : (b_x - a_x);
  assign match_o = (diff <= (W+1)'(TOL));

endmodule

// File: rtl/period_sync_gen.sv
// period_sync_gen: qualifies measured test-signal periods until stable, then holds
// lock and regenerates a phase-aligned sync pulse train that free-runs across short
// gaps in the test-signal edges.
//
//   state      | meaning
//   -----------+----------------------------------------------------------------
//   ST_IDLE    | block disabled or just out of reset, all outputs low
//   ST_ACQUIRE | collecting consecutive in-tolerance periods to build confidence
//   ST_LOCKED  | period accepted, phase counter running, sync pulses generated
module period_sync_gen
  import sync_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int TOL      = 2,
  parameter int LOCK_CNT = 4,
  parameter int MISS_MAX = 3,
  parameter int HOLD_MAX = 3,
  parameter int PULSE_W  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period_in,
  input  logic                period_valid,
  input  logic                edge_in,
  output logic                sync_out,
  output logic                locked,
  output logic [PERIOD_W-1:0] period_out,
  output logic                lost
);

  localparam int MC_W = $clog2(LOCK_CNT + 1);
  localparam int MS_W = $clog2(MISS_MAX + 1);
  localparam int HD_W = $clog2(HOLD_MAX + 1);

  sync_state_e         state_q, state_d;
  logic [PERIOD_W-1:0] ref_q, ref_d;
  logic [MC_W-1:0]     match_cnt_q, match_cnt_d;
  logic [MS_W-1:0]     miss_cnt_q, miss_cnt_d;
  logic [HD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [PERIOD_W-1:0] phase_q, phase_d;
  logic [PERIOD_W-1:0] cur_per_q, cur_per_d;
  logic [PERIOD_W-1:0] period_out_q, period_out_d;
  logic                sync_q, sync_d;
  logic                locked_q, locked_d;
  logic                lost_q, lost_d;

  logic                sample_ok;
  logic [PERIOD_W-1:0] cmp_ref;
  logic                tol_match;
  logic [MC_W-1:0]     acq_cnt_nxt;
  logic                acq_lock;
  logic                nat_wrap;
  logic                restart;
  logic                hold_drop;
  logic                miss_drop;
  logic                drop;

  // Periods too short to carry a full pulse plus a low cycle are never trusted.
  assign sample_ok = period_valid
                     && (period_in >= PERIOD_W'(2))
                     && (period_in >= PERIOD_W'(PULSE_W + 1));

  // One comparator serves both paths: last sample while acquiring, accepted period while locked.
  assign cmp_ref = (state_q == ST_LOCKED) ? period_out_q : ref_q;

  period_tol_cmp #(
    .W   (PERIOD_W),
    .TOL (TOL)
  ) u_tol_cmp (
    .a_i     (period_in),
    .b_i     (cmp_ref),
    .match_o (tol_match)
  );

  assign acq_cnt_nxt = ((match_cnt_q == '0) || !tol_match) ? MC_W'(1)
                                                           : (match_cnt_q + MC_W'(1));
  assign acq_lock    = (state_q == ST_ACQUIRE) && sample_ok
                       && (acq_cnt_nxt == MC_W'(LOCK_CNT));

  // The active period only changes at a restart, so a period update never cuts a cycle short.
  assign nat_wrap  = (state_q == ST_LOCKED) && (phase_q == (cur_per_q - PERIOD_W'(1)));
  assign restart   = nat_wrap || edge_in;
  assign hold_drop = nat_wrap && !edge_in
                     && ((hold_cnt_q + HD_W'(1)) == HD_W'(HOLD_MAX));
  assign miss_drop = (state_q == ST_LOCKED) && sample_ok && !tol_match
                     && ((miss_cnt_q + MS_W'(1)) == MS_W'(MISS_MAX));
  assign drop      = hold_drop || miss_drop;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; disable wins over every other condition.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:    state_d = ST_ACQUIRE;
        ST_ACQUIRE: if (acq_lock) state_d = ST_LOCKED;
        ST_LOCKED:  if (drop) state_d = ST_ACQUIRE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Counter and output next values for each state.
  always_comb begin
    ref_d        = ref_q;
    match_cnt_d  = match_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    phase_d      = phase_q;
    cur_per_d    = cur_per_q;
    period_out_d = period_out_q;
    locked_d     = 1'b0;
    lost_d       = 1'b0;
    sync_d       = 1'b0;

    if (!enable) begin
      ref_d        = '0;
      match_cnt_d  = '0;
      miss_cnt_d   = '0;
      hold_cnt_d   = '0;
      phase_d      = '0;
      cur_per_d    = '0;
      period_out_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          ref_d       = '0;
          match_cnt_d = '0;
          miss_cnt_d  = '0;
          hold_cnt_d  = '0;
          phase_d     = '0;
          cur_per_d   = '0;
        end
        ST_ACQUIRE: begin
          if (sample_ok) begin
            ref_d       = period_in;
            match_cnt_d = acq_cnt_nxt;
          end
          if (acq_lock) begin
            ref_d        = '0;
            match_cnt_d  = '0;
            miss_cnt_d   = '0;
            hold_cnt_d   = '0;
            phase_d      = '0;
            cur_per_d    = period_in;
            period_out_d = period_in;
            locked_d     = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (sample_ok) begin
            if (tol_match) begin
              period_out_d = period_in;
              miss_cnt_d   = '0;
            end else begin
              miss_cnt_d = miss_cnt_q + MS_W'(1);
            end
          end
          if (edge_in) begin
            hold_cnt_d = '0;
          end else if (nat_wrap) begin
            hold_cnt_d = hold_cnt_q + HD_W'(1);
          end
          if (restart) begin
            phase_d   = '0;
            cur_per_d = period_out_d;
          end else begin
            phase_d = phase_q + PERIOD_W'(1);
          end
          if (drop) begin
            ref_d       = '0;
            match_cnt_d = '0;
            miss_cnt_d  = '0;
            hold_cnt_d  = '0;
            phase_d     = '0;
            cur_per_d   = '0;
            lost_d      = 1'b1;
          end else begin
            locked_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    sync_d = locked_d && (phase_d < PERIOD_W'(PULSE_W));
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_q        <= '0;
      match_cnt_q  <= '0;
      miss_cnt_q   <= '0;
      hold_cnt_q   <= '0;
      phase_q      <= '0;
      cur_per_q    <= '0;
      period_out_q <= '0;
      sync_q       <= 1'b0;
      locked_q     <= 1'b0;
      lost_q       <= 1'b0;
    end else begin
      ref_q        <= ref_d;
      match_cnt_q  <= match_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      phase_q      <= phase_d;
      cur_per_q    <= cur_per_d;
      period_out_q <= period_out_d;
      sync_q       <= sync_d;
      locked_q     <= locked_d;
      lost_q       <= lost_d;
    end
  end

  assign sync_out   = sync_q;
  assign locked     = locked_q;
  assign period_out = period_out_q;
  assign lost       = lost_q;

endmodule
